// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported synchronous memory between the
//            instruction-fetch requester and the load/store requester.
//            Each transaction is latched at grant and then sequenced
//            through IDLE -> ACCESS -> (WAIT) -> DONE. The FSM pulses the
//            granted port's ack and registers read data for each port
//            separately.
// Ports    : clk, rst (async, active-low)
//            if_req/if_addr -> if_ack/if_rdata      fetch port (reads only)
//            d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   load/store port
//            mem_en/mem_we/mem_addr/mem_wdata, mem_rdata  memory side
//            busy : high whenever the FSM is not idle
// Options  : ARB_ROUND_ROBIN_EN -- when defined, a tie goes to the port
//            that did not win the previous grant. When undefined, data
//            always wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] C_MEM_LAT = 4'(MEM_LAT);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_gnt_d;     // 1 = current transaction belongs to the data port
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_grant;
  logic              w_gnt_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last_d;    // 1 = last grant went to the data port

  always_comb begin
    w_grant = if_req | d_req;
    if (if_req && d_req) begin
      w_gnt_d = ~r_last_d;
    end else begin
      w_gnt_d = d_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b1;
    end else if (r_state == S_IDLE && w_grant) begin
      r_last_d <= w_gnt_d;
    end
  end
`else
  // Data wins every tie, so the grant reduces to "data asked".
  always_comb begin
    w_grant = if_req | d_req;
    w_gnt_d = d_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            // Latch the winner so later input changes cannot disturb it.
            r_gnt_d <= w_gnt_d;
            r_addr  <= w_gnt_d ? d_addr : if_addr;
            r_we    <= w_gnt_d & d_we;
            r_wdata <= w_gnt_d ? d_wdata : '0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= C_MEM_LAT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // When the count reaches 1, mem_rdata is valid in this cycle.
          if (r_cnt == 4'd1) begin
            if (r_gnt_d) begin
              r_d_rdata <= mem_rdata;
            end else begin
              r_if_rdata <= mem_rdata;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (r_state == S_ACCESS);
  assign mem_we    = mem_en & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ack    = (r_state == S_DONE) & ~r_gnt_d;
  assign d_ack     = (r_state == S_DONE) &  r_gnt_d;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_arbiter
// Purpose  : Self-checking bench for unified_mem_arbiter. Instance 0 runs
//            with MEM_LAT=1 and instance 1 with MEM_LAT=3. Each instance has
//            its own latency-accurate memory model. Expected acks are queued
//            when stimulus is driven and are checked when they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req   [2];
  logic [7:0]  if_addr  [2];
  logic        if_ack   [2];
  logic [31:0] if_rdata [2];
  logic        d_req    [2];
  logic        d_we     [2];
  logic [7:0]  d_addr   [2];
  logic [31:0] d_wdata  [2];
  logic        d_ack    [2];
  logic [31:0] d_rdata  [2];
  logic        mem_en   [2];
  logic        mem_we   [2];
  logic [7:0]  mem_addr [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];
  logic        busy     [2];

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : 3;
    logic [31:0] mem [256];
    logic [7:0]  pa  [16];
    logic [15:0] pv = '0;

    // Read data becomes valid exactly LAT cycles after the mem_en cycle.
    always @(posedge clk) begin
      if (mem_en[k] && mem_we[k]) mem[mem_addr[k]] <= mem_wdata[k];
      pa[0] <= mem_addr[k];
      for (int i = 1; i < 16; i++) pa[i] <= pa[i-1];
      pv <= {pv[14:0], mem_en[k] & ~mem_we[k]};
    end
    assign mem_rdata[k] = pv[LAT-1] ? mem[pa[LAT-1]] : 32'hBADC0DE0;

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_ack(if_ack[k]), .if_rdata(if_rdata[k]),
      .d_req(d_req[k]), .d_we(d_we[k]), .d_addr(d_addr[k]), .d_wdata(d_wdata[k]),
      .d_ack(d_ack[k]), .d_rdata(d_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]), .busy(busy[k])
    );
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          inst;
    bit          is_d;
    int          start;
    int          lat;
    logic [31:0] if_rd;
    logic [31:0] d_rd;
  } exp_t;
  exp_t sb[$];

  logic [31:0] exp_if[2];
  logic [31:0] exp_d [2];

  typedef struct {
    int          inst;
    bit          is_d;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  addr2;
    logic [31:0] rd;
  } vec_t;
  vec_t vt[14];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(int k, bit is_d, int lat, int start);
    exp_t e;
    e.inst  = k;
    e.is_d  = is_d;
    e.start = start;
    e.lat   = lat;
    e.if_rd = exp_if[k];
    e.d_rd  = exp_d[k];
    sb.push_back(e);
  endtask

  // Ack monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (if_ack[k] === 1'b1 || d_ack[k] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: inst %0d if_ack %b d_ack %b, required none", k, if_ack[k], d_ack[k]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_inst", 64'(k), 64'(e.inst));
          chk("ack_port", {if_ack[k], d_ack[k]}, e.is_d ? 64'h1 : 64'h2);
          chk("ack_cycle", 64'(cyc - e.start), 64'(e.lat));
          chk("if_rdata", if_rdata[k], e.if_rd);
          chk("d_rdata", d_rdata[k], e.d_rd);
        end
      end
    end
  end

  task automatic run_txn(int k, bit is_d, bit we, logic [7:0] addr, logic [31:0] wdata,
                         logic [7:0] addr2, logic [31:0] exp_rd, string tag);
    int  lat;
    bit  seen;
    lat  = we ? 2 : lat_of(k) + 2;
    seen = 1'b0;
    @(posedge clk); #1;
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    if (!we) begin
      if (is_d) exp_d[k] = exp_rd;
      else      exp_if[k] = exp_rd;
    end
    push(k, is_d, lat, cyc);
    for (int n = 0; n < lat + 4 && !seen; n++) begin
      @(negedge clk);
      chk({tag, "_mem_en"}, mem_en[k], 64'(n == 1));
      chk({tag, "_mem_we"}, mem_we[k], 64'(n == 1 && we));
      chk({tag, "_busy"}, busy[k], 64'(n != 0));
      if (n == 1) begin
        chk({tag, "_mem_addr"}, mem_addr[k], addr);
        if (we) chk({tag, "_mem_wdata"}, mem_wdata[k], wdata);
      end
      seen = is_d ? d_ack[k] : if_ack[k];
      @(posedge clk); #1;
      if (n == 0 && addr2 != addr) begin
        if (is_d) begin d_addr[k] = addr2; d_wdata[k] = ~wdata; end
        else if_addr[k] = addr2;
      end
    end
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ack within %0d cycles, required ack in cycle %0d", tag, lat + 4, lat);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    int st;
    int fa;
    int da;
    bit f;
    bit d;

    vt[0]  = '{0, 1'b1, 1'b1, 8'h04, 32'h00500093, 8'h04, 32'h0};
    vt[1]  = '{0, 1'b0, 1'b0, 8'h04, 32'h0,        8'h04, 32'h00500093};
    vt[2]  = '{0, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 8'h20, 32'h0};
    vt[3]  = '{0, 1'b1, 1'b1, 8'h40, 32'h12345678, 8'h40, 32'h0};
    vt[4]  = '{0, 1'b1, 1'b0, 8'h20, 32'h0,        8'h40, 32'hDEADBEEF};
    vt[5]  = '{0, 1'b0, 1'b0, 8'h40, 32'h0,        8'h40, 32'h12345678};
    vt[6]  = '{1, 1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 8'h20, 32'h0};
    vt[7]  = '{1, 1'b1, 1'b0, 8'h20, 32'h0,        8'h20, 32'hDEADBEEF};
    vt[8]  = '{1, 1'b0, 1'b0, 8'h20, 32'h0,        8'h10, 32'hDEADBEEF};
    vt[9]  = '{1, 1'b1, 1'b1, 8'h10, 32'hCAFEF00D, 8'h10, 32'h0};
    vt[10] = '{1, 1'b0, 1'b0, 8'h10, 32'h0,        8'h10, 32'hCAFEF00D};
    vt[11] = '{1, 1'b1, 1'b0, 8'h10, 32'h0,        8'h10, 32'hCAFEF00D};
    vt[12] = '{0, 1'b1, 1'b1, 8'hFC, 32'hA5A55A5A, 8'hFC, 32'h0};
    vt[13] = '{0, 1'b1, 1'b0, 8'hFC, 32'h0,        8'hFC, 32'hA5A55A5A};

    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; exp_if[k] = '0; exp_d[k] = '0;
    end
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctrl", {if_ack[k], d_ack[k], mem_en[k], mem_we[k], busy[k]}, 64'h0);
      chk("reset_data", {if_rdata[k], d_rdata[k]}, 64'h0);
      chk("reset_mem_bus", {mem_addr[k], mem_wdata[k]}, 64'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_txn(vt[i].inst, vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata,
              vt[i].addr2, vt[i].rd, $sformatf("vec%0d", i));
    end

    // Both ports request together, and each port stays asserted for two transactions.
    @(posedge clk); #1;
    if_req[0] = 1'b1; if_addr[0] = 8'h04;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h30; d_wdata[0] = 32'h11112222;
    st = cyc;
`ifdef ARB_ROUND_ROBIN_EN
    exp_if[0] = 32'h00500093;
    push(0, 1'b0, 3, st);
    push(0, 1'b1, 6, st);
    push(0, 1'b0, 10, st);
    push(0, 1'b1, 13, st);
`else
    push(0, 1'b1, 2, st);
    push(0, 1'b1, 5, st);
    exp_if[0] = 32'h00500093;
    push(0, 1'b0, 9, st);
    push(0, 1'b0, 13, st);
`endif
    fa = 0;
    da = 0;
    for (int n = 0; n < 30 && (fa < 2 || da < 2); n++) begin
      @(negedge clk);
      f = if_ack[0];
      d = d_ack[0];
      @(posedge clk); #1;
      if (f) begin fa++; if (fa == 2) if_req[0] = 1'b0; end
      if (d) begin da++; if (da == 2) d_req[0] = 1'b0; end
    end
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;
    chk("tie_if_acks", 64'(fa), 64'd2);
    chk("tie_d_acks", 64'(da), 64'd2);

    // An asynchronous reset in the middle of a MEM_LAT=3 read.
    @(posedge clk); #1;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h10;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", busy[1], 64'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_async_ctrl", {if_ack[1], d_ack[1], mem_en[1], mem_we[1], busy[1]}, 64'h0);
    chk("rst_async_data", {if_rdata[1], d_rdata[1]}, 64'h0);
    chk("rst_async_mem_bus", {mem_addr[1], mem_wdata[1]}, 64'h0);
    d_req[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_if[k] = '0;
      exp_d[k]  = '0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", busy[1], 64'h0);

    run_txn(1, 1'b0, 1'b0, 8'h10, 32'h0, 8'h10, 32'hCAFEF00D, "post_rst_fetch");

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported synchronous memory between the instruction-fetch path (driven from the PC) and the load/store path (ALU address, rs2 write data). It accepts req/ack transactions from both requesters and sequences the memory enable, write-enable and address. It registers read data per requester and exposes a busy flag so the control unit can hold PC_en low. This block lets the single-cycle CPU run against a unified instruction/data memory in multi-cycle fashion.

Parameters:
ADDR_W, 8, byte-address width of both requester ports and mem_addr
DATA_W, 32, data width
MEM_LAT, 1, memory read latency in cycles, from the mem_en cycle to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  one-cycle pulse; fetch complete
if_rdata  out  DATA_W  registered fetch data
d_req  in  1  data request; held high until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; data transaction complete
d_rdata  out  DATA_W  registered load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe, valid only with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; every output 0, including if_rdata, d_rdata, mem_* and busy; wait counter 0; last_grant = DATA. Reset during any state aborts the transaction and issues no ack.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: sample requests. On a grant, latch the winner's addr, we and wdata into internal registers, record the granted port, and go to ACCESS. With no request, stay in IDLE.
- Arbitration, base build: when both requests are high, the data port wins. Only a requester whose req is high can win.
- ACCESS (exactly 1 cycle):
  - Drive mem_en=1, mem_addr and mem_wdata from the latched copies, and mem_we = latched we. Fetches are always reads.
  - On a write, go to DONE.
  - On a read, load the counter with MEM_LAT and go to WAIT.
- WAIT: mem_en=0. Decrement the counter each cycle. In the cycle where counter==1, capture mem_rdata at the clock edge into the granted port's rdata register, then go to DONE.
- DONE (1 cycle): assert the granted port's ack only. Then go to IDLE.
- Latency, counted from the IDLE cycle with req high as cycle 0:
  - read: ack in cycle MEM_LAT+2
  - write: ack in cycle 2
- Minimum spacing between back-to-back transactions is one IDLE cycle. The requester must drop req, or present a new transaction, in the cycle after ack. req seen in DONE is ignored.
- if_rdata and d_rdata hold their values until that port's next read capture. Writes never change d_rdata.
- Input changes after the grant (addr, wdata, we) are ignored because the values are latched.
- Dropping req mid-transaction is a protocol violation. The transaction still completes and still acks.
- mem_en is high for exactly one cycle per transaction. mem_we is never high when mem_en is low.
- Addresses pass through unmodified. Word/byte selection is handled downstream.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined: when both requests are high in IDLE, grant the port not recorded in last_grant. last_grant updates on every grant. Reset value DATA means the first tie goes to fetch.
- Undefined: fixed data priority as above. last_grant logic is absent.
- Single-requester behaviour is identical in both builds.

Test Plan:
- MEM_LAT=1, if_req=1, if_addr=0x04, memory[0x04]=0x00500093 -> mem_en high in cycle 1 with mem_addr=0x04 and mem_we=0; if_ack in cycle 3; if_rdata=0x00500093; busy high in cycles 1-3.
- MEM_LAT=1, d_req=1, d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF; d_ack in cycle 2; d_rdata unchanged.
- MEM_LAT=3, d_req=1, d_we=0, d_addr=0x20 after the previous store -> d_ack in cycle 5; d_rdata=0xDEADBEEF; mem_en high only in cycle 1.
- if_req and d_req both high from cycle 0 -> base build: d_ack first, then if_ack. With ARB_ROUND_ROBIN_EN: if_ack first, then d_ack, and grants alternate while both stay high.
- rst driven low in WAIT of a read -> all outputs 0 immediately without waiting for clk; no ack; after release, the next if_req completes normally.
- Change d_addr from 0x20 to 0x40 one cycle after the grant -> mem_addr=0x20 and the data is from 0x20.
